// File: rtl/mips_lsu_pkg.sv
// Shared size encoding, FSM and strobe encodings, and the alignment check
// used by the MIPS load/store unit and its load-extension datapath.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  // One-hot-or-none strobe towards mips_data; read and write can never coexist.
  typedef enum logic [1:0] {
    STB_NONE  = 2'b00,
    STB_READ  = 2'b01,
    STB_WRITE = 2'b10
  } mem_strobe_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_load_extend.sv
// Combinational sign/zero extension of right-justified load data.
module mips_load_extend
  import mips_lsu_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ext_o
);

  // Upper bits of sub-word data are don't-care and are replaced here.
  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SZ_BYTE: ext_o = uns_i ? {24'h000000, raw_i[7:0]}  : {{24{raw_i[7]}}, raw_i[7:0]};
      SZ_HALF: ext_o = uns_i ? {16'h0000, raw_i[15:0]}   : {{16{raw_i[15]}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Data-memory initiator: one request at a time, fixed read latency,
// single-cycle response with error flag for misaligned/illegal accesses.
module mips_load_store_unit #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  output logic [1:0]  s,
  input  logic [31:0] read_data
);
  import mips_lsu_pkg::*;

  localparam logic [3:0] LAT4 = 4'(READ_LAT);

  lsu_state_e  state_q, state_d;
  mem_strobe_e strobe_q, strobe_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  s_q, s_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ext_data;

  mips_load_extend u_extend (
    .raw_i  (read_data),
    .size_i (size_q),
    .uns_i  (uns_q),
    .ext_o  (ext_data)
  );

  // Next-state and next-output decode; all outputs leave the unit from flops.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    strobe_d     = STB_NONE;
    mem_addr_d   = 32'd0;
    wdata_d      = 32'd0;
    s_d          = 2'b00;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ST_ACCESS;
            mem_addr_d = req_addr;
            s_d        = req_size;
            if (req_write) begin
              strobe_d = STB_WRITE;
              wdata_d  = req_wdata;
              cnt_d    = 4'd0;
            end else begin
              strobe_d = STB_READ;
              cnt_d    = LAT4;
            end
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (write_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
        end else if (cnt_q == 4'd1) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = ext_data;
          cnt_d        = 4'd0;
        end else begin
          cnt_d      = cnt_q - 4'd1;
          strobe_d   = STB_READ;
          mem_addr_d = mem_addr_q;
          s_d        = s_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      strobe_q     <= STB_NONE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      size_q       <= SZ_WORD;
      uns_q        <= 1'b0;
      mem_addr_q   <= 32'd0;
      wdata_q      <= 32'd0;
      s_q          <= 2'b00;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      s_q          <= s_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready     = ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = rdata_q;
  assign mem_address   = mem_addr_q;
  assign write_data    = wdata_q;
  assign s             = s_q;
  assign sig_mem_read  = (strobe_q == STB_READ);
  assign sig_mem_write = (strobe_q == STB_WRITE);

endmodule

// File: doc/mips_load_store_unit.md
# mips_load_store_unit

Initiator side of the data-memory interface. Accepts one load/store request at a time from the datapath and drives `mem_address`/`write_data`/`sig_mem_read`/`sig_mem_write`/`s` into `mips_data`. It waits a programmable read latency, captures `read_data`, and sign- or zero-extends it. It returns a single-cycle response, with an error flag for misaligned or illegal-size accesses.

## Interface
- `READ_LAT`, default 1: cycles `sig_mem_read` is held before `read_data` is sampled; legal 1..15.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; handshake when `req_valid && req_ready` at a posedge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal size; valid with `resp_valid`.
- `mem_address`  out  32  to `mips_data`.
- `write_data`  out  32  to `mips_data`.
- `sig_mem_read`  out  1  to `mips_data`.
- `sig_mem_write`  out  1  to `mips_data`.
- `s`  out  2  size to `mips_data`, same encoding as `req_size`.
- `read_data`  in  32  from `mips_data`; right-justified, upper bits don't-care for sub-word.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - ACCESS: memory strobe asserted.
  - RESP: `resp_valid`=1.
- IDLE, handshake:
  - Latch `req_*`.
  - Illegal if `req_size`=11, or halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Legal → ACCESS. Illegal → RESP with `resp_err`=1; no memory strobe is ever asserted.
- ACCESS, store: exactly 1 cycle.
  - `sig_mem_write`=1.
  - `write_data`=`req_wdata`, `mem_address`=`req_addr`, `s`=`req_size`.
  - → RESP.
- ACCESS, load: `sig_mem_read`=1 for exactly `READ_LAT` cycles, counted by a 4-bit down-counter.
  - On the final ACCESS posedge, capture `read_data` and extend it.
  - Byte: bit 7 sign or zero. Halfword: bit 15 sign or zero. Word: unchanged; `req_unsigned` ignored.
  - → RESP.
- RESP: 1 cycle → IDLE. `resp_rdata`/`resp_err` are valid only in this cycle.
- Reset values: state IDLE, `req_ready`=1, every other output 0, counter 0.
- Outside ACCESS, both strobes are 0 and `mem_address`/`write_data`/`s` are 0.
- Never are both strobes high at once.

## Timing
- Handshake at posedge T (end of cycle T) → ACCESS spans cycles T+1..T+`READ_LAT` for loads and cycle T+1 for stores.
- `resp_valid` timing:
  - Load: high in cycle T+`READ_LAT`+1.
  - Store: high in cycle T+2.
  - Error: high in cycle T+1.
- Throughput: next handshake no earlier than the posedge ending RESP; `req_ready`=0 from cycle T+1 until back in IDLE.
- `req_valid` while busy is ignored, not queued. Request inputs need be stable only at the handshake edge.
- `rst` high at any posedge forces IDLE and all reset values at that edge. No response is produced for the aborted request.
- A store whose ACCESS cycle coincides with `rst` still commits in `mips_data`, because the strobe is high at that edge; the bench must accept this.
- `rst` and `req_valid` together: reset wins; no handshake.

## Structure
- Package `mips_lsu_pkg`:
  - Size constants `SZ_WORD`=2'b00, `SZ_HALF`=2'b01, `SZ_BYTE`=2'b10, `SZ_ILL`=2'b11.
  - FSM state encoding.
  - Misalignment function.
  - The `mips_data` strobe encoding is shared from here.
- Sub-module `mips_load_extend`: combinational, inputs raw data, size and unsigned; outputs 32-bit extended value. Instantiated once; the unit registers its output.

## Test plan
- Load byte, signed: addr 0x00000001, size 10, unsigned=0, memory returns 0x000000F3, `READ_LAT`=1 → `sig_mem_read` high exactly 1 cycle; `resp_rdata`=0xFFFFFFF3, `resp_err`=0, `resp_valid` 2 cycles after handshake.
- Load halfword, unsigned: addr 0x00000002, size 01, returns 0x00008001, `READ_LAT`=3 → `sig_mem_read` high 3 cycles; `resp_rdata`=0x00008001 at T+4.
- Store word: addr 0x00000004, wdata 0xFFFFFFFF, size 00 → one cycle with `sig_mem_write`=1, `s`=00, `mem_address`=0x4, `write_data`=0xFFFFFFFF; `resp_valid` at T+2 with `resp_rdata`=0. Readback load of 0x4 returns 0xFFFFFFFF.
- Misaligned/illegal: word at 0x00000003, then halfword at 0x00000001, then size 11 → each gives `resp_err`=1 at T+1; strobes never leave 0.
- Busy/back-to-back: `req_valid` held high for three loads → handshakes only in IDLE; exactly three `resp_valid` pulses, spaced `READ_LAT`+2 cycles apart.
- Reset mid-load: `READ_LAT`=4, assert `rst` in the second ACCESS cycle → next cycle IDLE, `sig_mem_read`=0, `req_ready`=1, no `resp_valid`.
